baseband_vga_agc: RTL and testbench

Closed-loop automatic gain controller for the baseband receive chain. Watches the 8-bit I and Q ADC sample streams, measures the peak magnitude over fixed sample windows, and steps the two 10-bit VGA attenuation words up or down to keep the peak inside a programmable band. Sits between the baseband RX datapath and the `baseband_tuning_i_vgaAtten` / `baseband_tuning_q_vgaAtten` pad outputs. Replaces static MMIO tuning of those words while the AGC is enabled.

---
 rtl/agc_pkg.sv | 24 ++
 rtl/agc_channel.sv | 69 ++++++
 rtl/baseband_vga_agc.sv | 148 ++++++++++++++
 tb/tb_baseband_vga_agc.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/agc_pkg.sv
// Shared types and constants for the baseband VGA automatic gain controller.
package agc_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    UPDATE  = 2'd2
  } agc_state_t;

  localparam int ATTEN_W  = 10;
  localparam int SAMPLE_W = 8;
  localparam logic [SAMPLE_W-1:0] MIDSCALE  = 8'd128;
  localparam logic [ATTEN_W-1:0]  ATTEN_MAX = 10'd1023;

  // Distance of an offset-binary ADC code from midscale; 0..128 fits in 8 bits.
  function automatic logic [SAMPLE_W-1:0] sample_mag(input logic [SAMPLE_W-1:0] x);
    if (x >= MIDSCALE) begin
      sample_mag = x - MIDSCALE;
    end else begin
      sample_mag = MIDSCALE - x;
    end
  endfunction

endpackage

// File: rtl/agc_channel.sv
// One AGC channel: sample magnitude, window peak tracker, threshold compare and
// saturating attenuation register.
module agc_channel
  import agc_pkg::*;
#(
  parameter logic [9:0] RESET_ATTEN = 10'd512
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       load,
  input  logic [9:0] init_atten,
  input  logic       accumulate,
  input  logic       restart,
  input  logic       adjust,
  input  logic       sample_valid,
  input  logic [7:0] sample,
  input  logic [7:0] thresh_hi,
  input  logic [7:0] thresh_lo,
  input  logic [4:0] step,
  output logic [9:0] atten,
  output logic       in_band
);

  logic [7:0]  mag;
  logic [7:0]  peak;
  logic [10:0] sum;
  logic [9:0]  atten_next;
  logic        above;
  logic        below;

  // Hi compare is evaluated first so it wins when the band is misconfigured.
  always_comb begin
    mag        = sample_mag(sample);
    above      = (peak > thresh_hi);
    below      = (peak < thresh_lo);
    in_band    = !above && !below;
    sum        = {1'b0, atten} + {6'b000000, step};
    atten_next = atten;
    if (above) begin
      atten_next = (sum > {1'b0, ATTEN_MAX}) ? ATTEN_MAX : sum[9:0];
    end else if (below) begin
      atten_next = (atten >= {5'b00000, step}) ? (atten - {5'b00000, step}) : 10'd0;
    end else begin
      atten_next = atten;
    end
  end

  // Peak and attenuation state; a restart seeds the peak with any sample
  // arriving in the same cycle so the next window does not lose it.
  always_ff @(posedge clock) begin
    if (reset) begin
      atten <= RESET_ATTEN;
      peak  <= 8'd0;
    end else if (load) begin
      atten <= init_atten;
      peak  <= 8'd0;
    end else begin
      if (adjust) begin
        atten <= atten_next;
      end
      if (restart) begin
        peak <= sample_valid ? mag : 8'd0;
      end else if (accumulate && (mag > peak)) begin
        peak <= mag;
      end
    end
  end

endmodule

// File: rtl/baseband_vga_agc.sv
// Closed-loop AGC for the I/Q baseband receive chain: window FSM, window
// counter and lock counter around two per-channel attenuation trackers.
module baseband_vga_agc
  import agc_pkg::*;
#(
  parameter int         WINDOW_LOG2 = 6,
  parameter int         LOCK_COUNT  = 4,
  parameter logic [9:0] RESET_ATTEN = 10'd512
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  input  logic       freeze,
  input  logic       rx_valid,
  input  logic [7:0] rx_i_data,
  input  logic [7:0] rx_q_data,
  input  logic [9:0] cfg_init_atten,
  input  logic [7:0] cfg_thresh_hi,
  input  logic [7:0] cfg_thresh_lo,
  input  logic [4:0] cfg_step,
  output logic [9:0] vga_atten_i,
  output logic [9:0] vga_atten_q,
  output logic       locked,
  output logic       active
);

  localparam int LOCK_W = $clog2(LOCK_COUNT + 1);
  localparam logic [LOCK_W-1:0]      LOCK_FULL = LOCK_W'(LOCK_COUNT);
  localparam logic [WINDOW_LOG2-1:0] WIN_LAST  = {WINDOW_LOG2{1'b1}};

  agc_state_t              state, state_next;
  logic [WINDOW_LOG2-1:0]  wcnt, wcnt_next;
  logic [LOCK_W-1:0]       lock_cnt, lock_next;
  logic                    load, accumulate, restart, adjust;
  logic                    in_band_i, in_band_q;

  // Next-state and per-cycle channel controls.
  always_comb begin
    state_next = state;
    wcnt_next  = wcnt;
    lock_next  = lock_cnt;
    load       = 1'b0;
    accumulate = 1'b0;
    restart    = 1'b0;
    adjust     = 1'b0;
    case (state)
      IDLE: begin
        if (enable) begin
          state_next = MEASURE;
          load       = 1'b1;
          wcnt_next  = {WINDOW_LOG2{1'b0}};
          lock_next  = {LOCK_W{1'b0}};
        end else begin
          state_next = IDLE;
        end
      end
      MEASURE: begin
        if (!enable) begin
          state_next = IDLE;
          lock_next  = {LOCK_W{1'b0}};
        end else if (freeze) begin
          state_next = MEASURE;
        end else if (rx_valid) begin
          accumulate = 1'b1;
          wcnt_next  = wcnt + WINDOW_LOG2'(1);
          state_next = (wcnt == WIN_LAST) ? UPDATE : MEASURE;
        end else begin
          state_next = MEASURE;
        end
      end
      UPDATE: begin
        if (!enable) begin
          state_next = IDLE;
          lock_next  = {LOCK_W{1'b0}};
        end else if (freeze) begin
          state_next = UPDATE;
        end else begin
          state_next = MEASURE;
          adjust     = 1'b1;
          restart    = 1'b1;
          wcnt_next  = rx_valid ? WINDOW_LOG2'(1) : {WINDOW_LOG2{1'b0}};
          if (in_band_i && in_band_q) begin
            lock_next = (lock_cnt == LOCK_FULL) ? LOCK_FULL : (lock_cnt + LOCK_W'(1));
          end else begin
            lock_next = {LOCK_W{1'b0}};
          end
        end
      end
      default: begin
        state_next = IDLE;
        lock_next  = {LOCK_W{1'b0}};
      end
    endcase
  end

  // Control registers; locked/active follow the next-cycle values so they
  // change in the same cycle as the counter and state they describe.
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      wcnt     <= {WINDOW_LOG2{1'b0}};
      lock_cnt <= {LOCK_W{1'b0}};
      locked   <= 1'b0;
      active   <= 1'b0;
    end else begin
      state    <= state_next;
      wcnt     <= wcnt_next;
      lock_cnt <= lock_next;
      locked   <= (lock_next == LOCK_FULL);
      active   <= (state_next != IDLE);
    end
  end

  agc_channel #(.RESET_ATTEN(RESET_ATTEN)) u_chan_i (
    .clock       (clock),
    .reset       (reset),
    .load        (load),
    .init_atten  (cfg_init_atten),
    .accumulate  (accumulate),
    .restart     (restart),
    .adjust      (adjust),
    .sample_valid(rx_valid),
    .sample      (rx_i_data),
    .thresh_hi   (cfg_thresh_hi),
    .thresh_lo   (cfg_thresh_lo),
    .step        (cfg_step),
    .atten       (vga_atten_i),
    .in_band     (in_band_i)
  );

  agc_channel #(.RESET_ATTEN(RESET_ATTEN)) u_chan_q (
    .clock       (clock),
    .reset       (reset),
    .load        (load),
    .init_atten  (cfg_init_atten),
    .accumulate  (accumulate),
    .restart     (restart),
    .adjust      (adjust),
    .sample_valid(rx_valid),
    .sample      (rx_q_data),
    .thresh_hi   (cfg_thresh_hi),
    .thresh_lo   (cfg_thresh_lo),
    .step        (cfg_step),
    .atten       (vga_atten_q),
    .in_band     (in_band_q)
  );

endmodule

// File: tb/tb_baseband_vga_agc.sv
// Directed bench for baseband_vga_agc: a table of whole-window scenarios plus
// hand sequences for enable drop, freeze, UPDATE-cycle samples and reset.
module tb_baseband_vga_agc;

  logic       clock;
  logic       reset;
  logic       enable;
  logic       freeze;
  logic       rx_valid;
  logic [7:0] rx_i_data;
  logic [7:0] rx_q_data;
  logic [9:0] cfg_init_atten;
  logic [7:0] cfg_thresh_hi;
  logic [7:0] cfg_thresh_lo;
  logic [4:0] cfg_step;
  logic [9:0] vga_atten_i;
  logic [9:0] vga_atten_q;
  logic       locked;
  logic       active;

  int nvec = 0;
  int nmis = 0;

  typedef struct {
    logic [9:0] init;
    logic [7:0] hi;
    logic [7:0] lo;
    logic [4:0] step;
    logic [7:0] i;
    logic [7:0] q;
    int         nwin;
    logic [9:0] exp_i;
    logic [9:0] exp_q;
    logic       exp_lock;
  } vec_t;

  vec_t tbl [8];

  baseband_vga_agc dut (
    .clock         (clock),
    .reset         (reset),
    .enable        (enable),
    .freeze        (freeze),
    .rx_valid      (rx_valid),
    .rx_i_data     (rx_i_data),
    .rx_q_data     (rx_q_data),
    .cfg_init_atten(cfg_init_atten),
    .cfg_thresh_hi (cfg_thresh_hi),
    .cfg_thresh_lo (cfg_thresh_lo),
    .cfg_step      (cfg_step),
    .vga_atten_i   (vga_atten_i),
    .vga_atten_q   (vga_atten_q),
    .locked        (locked),
    .active        (active)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    enable   = 1'b0;
    freeze   = 1'b0;
    rx_valid = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  task automatic start(input logic [9:0] init, input logic [7:0] hi,
                       input logic [7:0] lo, input logic [4:0] step);
    cfg_init_atten = init;
    cfg_thresh_hi  = hi;
    cfg_thresh_lo  = lo;
    cfg_step       = step;
    enable         = 1'b1;
    tick();
  endtask

  task automatic samples(input int n, input logic [7:0] i, input logic [7:0] q);
    for (int k = 0; k < n; k++) begin
      rx_valid  = 1'b1;
      rx_i_data = i;
      rx_q_data = q;
      tick();
    end
    rx_valid = 1'b0;
  endtask

  // 64 samples, then the UPDATE cycle.
  task automatic window(input logic [7:0] i, input logic [7:0] q);
    samples(64, i, q);
    tick();
  endtask

  initial begin
    reset = 1'b0; enable = 1'b0; freeze = 1'b0; rx_valid = 1'b0;
    rx_i_data = 8'd128; rx_q_data = 8'd128;
    cfg_init_atten = 10'd0; cfg_thresh_hi = 8'd0; cfg_thresh_lo = 8'd0; cfg_step = 5'd0;

    //          init    hi     lo     step  I       Q      nwin exp_i    exp_q    lock
    tbl[0] = '{10'd300, 8'd100, 8'd60, 5'd8,  8'd208, 8'd208, 3, 10'd300, 10'd300, 1'b0};
    tbl[1] = '{10'd300, 8'd100, 8'd60, 5'd8,  8'd208, 8'd208, 5, 10'd300, 10'd300, 1'b1};
    tbl[2] = '{10'd300, 8'd100, 8'd60, 5'd8,  8'd250, 8'd200, 3, 10'd324, 10'd300, 1'b0};
    tbl[3] = '{10'd4,   8'd100, 8'd60, 5'd8,  8'd130, 8'd130, 2, 10'd0,   10'd0,   1'b0};
    tbl[4] = '{10'd1020,8'd100, 8'd60, 5'd8,  8'd255, 8'd1,   2, 10'd1023,10'd1023,1'b0};
    tbl[5] = '{10'd300, 8'd80,  8'd80, 5'd8,  8'd208, 8'd48,  4, 10'd300, 10'd300, 1'b1};
    tbl[6] = '{10'd300, 8'd50,  8'd100,5'd8,  8'd208, 8'd168, 1, 10'd308, 10'd292, 1'b0};
    tbl[7] = '{10'd1000,8'd100, 8'd60, 5'd31, 8'd250, 8'd138, 1, 10'd1023,10'd969, 1'b0};

    // Reset state
    do_reset();
    chk("reset_atten_i", vga_atten_i, 10'd512);
    chk("reset_atten_q", vga_atten_q, 10'd512);
    chk("reset_locked", locked, 1'b0);
    chk("reset_active", active, 1'b0);

    for (int v = 0; v < 8; v++) begin
      do_reset();
      start(tbl[v].init, tbl[v].hi, tbl[v].lo, tbl[v].step);
      chk($sformatf("v%0d_init_i", v), vga_atten_i, tbl[v].init);
      for (int w = 0; w < tbl[v].nwin; w++) window(tbl[v].i, tbl[v].q);
      chk($sformatf("v%0d_atten_i", v), vga_atten_i, tbl[v].exp_i);
      chk($sformatf("v%0d_atten_q", v), vga_atten_q, tbl[v].exp_q);
      chk($sformatf("v%0d_locked", v), locked, tbl[v].exp_lock);
      chk($sformatf("v%0d_active", v), active, 1'b1);
    end

    // Lock builds over four in-band windows, then a mid-window reset.
    do_reset();
    start(10'd300, 8'd100, 8'd60, 5'd8);
    chk("lock_active", active, 1'b1);
    for (int w = 1; w <= 5; w++) begin
      window(8'd208, 8'd208);
      chk($sformatf("lock_w%0d", w), locked, (w >= 4) ? 1'b1 : 1'b0);
    end
    samples(10, 8'd255, 8'd255);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midrst_atten_i", vga_atten_i, 10'd512);
    chk("midrst_atten_q", vga_atten_q, 10'd512);
    chk("midrst_locked", locked, 1'b0);
    chk("midrst_active", active, 1'b0);

    // Enable drop mid-window, then re-enable with a new init value.
    do_reset();
    start(10'd300, 8'd100, 8'd60, 5'd8);
    window(8'd250, 8'd208);
    chk("en_first_i", vga_atten_i, 10'd308);
    samples(30, 8'd250, 8'd208);
    enable = 1'b0;
    tick();
    chk("en_drop_active", active, 1'b0);
    chk("en_drop_hold_i", vga_atten_i, 10'd308);
    chk("en_drop_hold_q", vga_atten_q, 10'd300);
    chk("en_drop_locked", locked, 1'b0);
    start(10'd200, 8'd100, 8'd60, 5'd8);
    chk("en_re_i", vga_atten_i, 10'd200);
    chk("en_re_active", active, 1'b1);
    samples(63, 8'd250, 8'd208);
    tick(); tick();
    chk("en_63_i", vga_atten_i, 10'd200);
    samples(1, 8'd250, 8'd208);
    chk("en_upd_cycle_i", vga_atten_i, 10'd200);
    tick();
    chk("en_64_i", vga_atten_i, 10'd208);

    // Freeze for 20 cycles mid-window with large samples, then freeze in UPDATE.
    do_reset();
    start(10'd300, 8'd100, 8'd60, 5'd8);
    samples(32, 8'd208, 8'd250);
    freeze = 1'b1;
    for (int k = 0; k < 20; k++) begin
      rx_valid = 1'b1; rx_i_data = 8'd255; rx_q_data = 8'd255;
      tick();
    end
    freeze = 1'b0;
    rx_valid = 1'b0;
    samples(31, 8'd208, 8'd250);
    tick(); tick();
    chk("frz_early_q", vga_atten_q, 10'd300);
    samples(1, 8'd208, 8'd250);
    freeze = 1'b1;
    for (int k = 0; k < 5; k++) tick();
    chk("frz_upd_q", vga_atten_q, 10'd300);
    freeze = 1'b0;
    tick();
    chk("frz_done_q", vga_atten_q, 10'd308);
    chk("frz_done_i", vga_atten_i, 10'd300);

    // A sample during UPDATE seeds the next window's peak and count.
    samples(64, 8'd208, 8'd208);
    rx_valid = 1'b1; rx_i_data = 8'd255; rx_q_data = 8'd208;
    tick();
    rx_valid = 1'b0;
    chk("upd_smp_i0", vga_atten_i, 10'd300);
    samples(62, 8'd208, 8'd208);
    tick(); tick();
    chk("upd_smp_early_i", vga_atten_i, 10'd300);
    samples(1, 8'd208, 8'd208);
    tick();
    chk("upd_smp_i", vga_atten_i, 10'd308);
    chk("upd_smp_q", vga_atten_q, 10'd308);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
